// File: rtl/intersection_controller.sv
// Two-phase (north-south / east-west) intersection sequencer with a
// pedestrian walk phase. A single shared down-counter times every state
// and is reloaded with that state's duration on each state entry.
module intersection_controller #(
  parameter int GREEN_T  = 30,
  parameter int YEL_T    = 5,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 10,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic n_reset,
  input  logic ped_req,
  output logic ns_red,
  output logic ns_yel,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yel,
  output logic ew_green,
  output logic walk,
  output logic ped_wait
);

  typedef enum logic [2:0] {
    ALLRED = 3'd0,
    NS_GRN = 3'd1,
    NS_YEL = 3'd2,
    EW_GRN = 3'd3,
    EW_YEL = 3'd4,
    WALK   = 3'd5
  } state_t;

  // Timer reload values: a state of duration D counts D-1 down to 0.
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YEL_LD    = CNT_W'(YEL_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_T - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] load_val;
  logic             next_dir_reg, next_dir_next;   // 0 = NS green next, 1 = EW
  logic             ped_wait_reg, ped_wait_next;
  logic             done;

  assign done = (cnt_reg == '0);

  // State, timer, direction and pedestrian-latch registers.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_reg    <= ALLRED;
      cnt_reg      <= ALLRED_LD;
      next_dir_reg <= 1'b0;
      ped_wait_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      next_dir_reg <= next_dir_next;
      ped_wait_reg <= ped_wait_next;
    end
  end

  // Next-state and direction selection; the state only moves when the timer expires.
  // A request arriving on the clearance's final cycle is served immediately.
  always_comb begin
    state_next    = state_reg;
    next_dir_next = next_dir_reg;
    if (done) begin
      case (state_reg)
        NS_GRN: state_next = NS_YEL;
        NS_YEL: begin
          state_next    = ALLRED;
          next_dir_next = 1'b1;
        end
        EW_GRN: state_next = EW_YEL;
        EW_YEL: begin
          state_next    = ALLRED;
          next_dir_next = 1'b0;
        end
        ALLRED: begin
          if (ped_wait_reg || ped_req) begin
            state_next = WALK;
          end else begin
            state_next = next_dir_reg ? EW_GRN : NS_GRN;
          end
        end
        WALK:    state_next = next_dir_reg ? EW_GRN : NS_GRN;
        default: state_next = ALLRED;
      endcase
    end
  end

  // Duration reload for whichever state is being entered.
  always_comb begin
    case (state_next)
      NS_GRN, EW_GRN: load_val = GREEN_LD;
      NS_YEL, EW_YEL: load_val = YEL_LD;
      WALK:           load_val = WALK_LD;
      default:        load_val = ALLRED_LD;
    endcase
  end

  // Timer reloads on every transition, otherwise counts down; never underflows.
  always_comb begin
    cnt_next = cnt_reg - CNT_W'(1);
    if (done) begin
      cnt_next = load_val;
    end
  end

  // Pedestrian latch: entering WALK clears it and takes priority over a new request.
  always_comb begin
    ped_wait_next = ped_wait_reg;
    if (done && (state_next == WALK)) begin
      ped_wait_next = 1'b0;
    end else if ((state_reg != WALK) && ped_req) begin
      ped_wait_next = 1'b1;
    end
  end

  // Moore lamp decode from the state register.
  always_comb begin
    ns_red   = 1'b0;
    ns_yel   = 1'b0;
    ns_green = 1'b0;
    ew_red   = 1'b0;
    ew_yel   = 1'b0;
    ew_green = 1'b0;
    walk     = 1'b0;
    case (state_reg)
      NS_GRN: begin
        ns_green = 1'b1;
        ew_red   = 1'b1;
      end
      NS_YEL: begin
        ns_yel = 1'b1;
        ew_red = 1'b1;
      end
      EW_GRN: begin
        ns_red   = 1'b1;
        ew_green = 1'b1;
      end
      EW_YEL: begin
        ns_red = 1'b1;
        ew_yel = 1'b1;
      end
      WALK: begin
        ns_red = 1'b1;
        ew_red = 1'b1;
        walk   = 1'b1;
      end
      default: begin
        ns_red = 1'b1;
        ew_red = 1'b1;
      end
    endcase
  end

  assign ped_wait = ped_wait_reg;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed testbench for intersection_controller: three instances cover the
// short test parameters, the default parameters and all-durations-one.
module tb_intersection_controller;

  // Lamp patterns {ns_red,ns_yel,ns_green,ew_red,ew_yel,ew_green,walk}
  localparam logic [6:0] AR = 7'b100_100_0;
  localparam logic [6:0] NG = 7'b001_100_0;
  localparam logic [6:0] NY = 7'b010_100_0;
  localparam logic [6:0] EG = 7'b100_001_0;
  localparam logic [6:0] EY = 7'b100_010_0;
  localparam logic [6:0] WK = 7'b100_100_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  // Instance A: GREEN 4, YEL 2, ALLRED 1, WALK 3
  logic a_rst_n = 1'b0, a_ped = 1'b0;
  logic a_nr, a_ny, a_ng, a_er, a_ey, a_eg, a_wk, a_pw;
  logic [6:0] a_l;
  assign a_l = {a_nr, a_ny, a_ng, a_er, a_ey, a_eg, a_wk};

  intersection_controller #(.GREEN_T(4), .YEL_T(2), .ALLRED_T(1), .WALK_T(3), .CNT_W(3)) dut_a (
    .clk(clk), .n_reset(a_rst_n), .ped_req(a_ped),
    .ns_red(a_nr), .ns_yel(a_ny), .ns_green(a_ng),
    .ew_red(a_er), .ew_yel(a_ey), .ew_green(a_eg),
    .walk(a_wk), .ped_wait(a_pw)
  );

  // Instance B: default parameters
  logic b_rst_n = 1'b0, b_ped = 1'b0;
  logic b_nr, b_ny, b_ng, b_er, b_ey, b_eg, b_wk, b_pw;
  logic [6:0] b_l;
  assign b_l = {b_nr, b_ny, b_ng, b_er, b_ey, b_eg, b_wk};

  intersection_controller dut_b (
    .clk(clk), .n_reset(b_rst_n), .ped_req(b_ped),
    .ns_red(b_nr), .ns_yel(b_ny), .ns_green(b_ng),
    .ew_red(b_er), .ew_yel(b_ey), .ew_green(b_eg),
    .walk(b_wk), .ped_wait(b_pw)
  );

  // Instance C: every duration 1
  logic c_rst_n = 1'b0, c_ped = 1'b0;
  logic c_nr, c_ny, c_ng, c_er, c_ey, c_eg, c_wk, c_pw;
  logic [6:0] c_l;
  assign c_l = {c_nr, c_ny, c_ng, c_er, c_ey, c_eg, c_wk};

  intersection_controller #(.GREEN_T(1), .YEL_T(1), .ALLRED_T(1), .WALK_T(1), .CNT_W(1)) dut_c (
    .clk(clk), .n_reset(c_rst_n), .ped_req(c_ped),
    .ns_red(c_nr), .ns_yel(c_ny), .ns_green(c_ng),
    .ew_red(c_er), .ew_yel(c_ey), .ew_green(c_eg),
    .walk(c_wk), .ped_wait(c_pw)
  );

  // Lamp pattern legality: one-hot per direction, no conflicting motion, walk only on all-red.
  function automatic bit lamps_ok(input logic [6:0] l);
    logic ns_act, ew_act;
    ns_act = l[5] | l[4];
    ew_act = l[2] | l[1];
    return $onehot(l[6:4]) && $onehot(l[3:1]) && !(ns_act && ew_act) && (!l[0] || (l[6] && l[3]));
  endfunction

  // Safety invariant watched on every falling edge once all instances are reset.
  always @(negedge clk) begin
    if (mon_en) begin
      checks += 3;
      if (!lamps_ok(a_l)) begin
        failures++;
        $display("FAIL safety_a lamps=%b is not a legal pattern", a_l);
      end
      if (!lamps_ok(b_l)) begin
        failures++;
        $display("FAIL safety_b lamps=%b is not a legal pattern", b_l);
      end
      if (!lamps_ok(c_l)) begin
        failures++;
        $display("FAIL safety_c lamps=%b is not a legal pattern", c_l);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Test 1: reset held, release, one full 14-cycle period with no requests.
  task automatic test_reset();
    logic [6:0] seq [15] = '{NG, NG, NG, NG, NY, NY, AR, EG, EG, EG, EG, EY, EY, AR, NG};
    a_rst_n = 1'b0;
    a_ped   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      mon_en = 1'b1;
      checks++;
      if (a_l !== AR || a_pw !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d] lamps=%b pw=%b expected lamps=%b pw=0", i, a_l, a_pw, AR);
      end
    end
    a_rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (a_l !== seq[i] || a_pw !== 1'b0) begin
        failures++;
        $display("FAIL period[%0d] lamps=%b pw=%b expected lamps=%b pw=0", i, a_l, a_pw, seq[i]);
      end
    end
  endtask

  // Test 2: one-cycle request in the 2nd NS green cycle -> walk, then EW green.
  // Vector fields: {ped_req driven for this edge, expected lamps, expected ped_wait}
  task automatic test_ped_pulse();
    logic [8:0] v [17] = '{
      {1'b0, NG, 1'b0}, {1'b1, NG, 1'b1}, {1'b0, NG, 1'b1}, {1'b0, NY, 1'b1},
      {1'b0, NY, 1'b1}, {1'b0, AR, 1'b1}, {1'b0, WK, 1'b0}, {1'b0, WK, 1'b0},
      {1'b0, WK, 1'b0}, {1'b0, EG, 1'b0}, {1'b0, EG, 1'b0}, {1'b0, EG, 1'b0},
      {1'b0, EG, 1'b0}, {1'b0, EY, 1'b0}, {1'b0, EY, 1'b0}, {1'b0, AR, 1'b0},
      {1'b0, NG, 1'b0}};
    for (int i = 0; i < 17; i++) begin
      a_ped = v[i][8];
      step();
      checks++;
      if (a_l !== v[i][7:1] || a_pw !== v[i][0]) begin
        failures++;
        $display("FAIL ped_pulse[%0d] lamps=%b pw=%b expected lamps=%b pw=%b", i, a_l, a_pw, v[i][7:1], v[i][0]);
      end
    end
    a_ped = 1'b0;
  endtask

  // Test 3: request held only through WALK is ignored; no second walk follows.
  task automatic test_ped_in_walk();
    logic [8:0] v [17] = '{
      {1'b0, NG, 1'b0}, {1'b1, NG, 1'b1}, {1'b0, NG, 1'b1}, {1'b0, NY, 1'b1},
      {1'b0, NY, 1'b1}, {1'b0, AR, 1'b1}, {1'b0, WK, 1'b0}, {1'b1, WK, 1'b0},
      {1'b1, WK, 1'b0}, {1'b1, EG, 1'b0}, {1'b0, EG, 1'b0}, {1'b0, EG, 1'b0},
      {1'b0, EG, 1'b0}, {1'b0, EY, 1'b0}, {1'b0, EY, 1'b0}, {1'b0, AR, 1'b0},
      {1'b0, NG, 1'b0}};
    for (int i = 0; i < 17; i++) begin
      a_ped = v[i][8];
      step();
      checks++;
      if (a_l !== v[i][7:1] || a_pw !== v[i][0]) begin
        failures++;
        $display("FAIL ped_in_walk[%0d] lamps=%b pw=%b expected lamps=%b pw=%b", i, a_l, a_pw, v[i][7:1], v[i][0]);
      end
    end
    a_ped = 1'b0;
  endtask

  // Test 4: request held continuously -> walk after every clearance, directions alternate.
  task automatic test_ped_held();
    logic [7:0] v [21] = '{
      {NG, 1'b1}, {NG, 1'b1}, {NG, 1'b1}, {NY, 1'b1}, {NY, 1'b1}, {AR, 1'b1},
      {WK, 1'b0}, {WK, 1'b0}, {WK, 1'b0}, {EG, 1'b0}, {EG, 1'b1}, {EG, 1'b1},
      {EG, 1'b1}, {EY, 1'b1}, {EY, 1'b1}, {AR, 1'b1}, {WK, 1'b0}, {WK, 1'b0},
      {WK, 1'b0}, {NG, 1'b0}, {NG, 1'b1}};
    a_ped = 1'b1;
    for (int i = 0; i < 21; i++) begin
      step();
      checks++;
      if (a_l !== v[i][7:1] || a_pw !== v[i][0]) begin
        failures++;
        $display("FAIL ped_held[%0d] lamps=%b pw=%b expected lamps=%b pw=%b", i, a_l, a_pw, v[i][7:1], v[i][0]);
      end
    end
    a_ped = 1'b0;
  endtask

  // Test 5: default parameters, reset pulse in the 3rd EW green cycle with a request pending.
  task automatic test_reset_mid();
    b_rst_n = 1'b0;
    b_ped   = 1'b0;
    step();
    checks++;
    if (b_l !== AR || b_pw !== 1'b0) begin
      failures++;
      $display("FAIL b_reset lamps=%b pw=%b expected lamps=%b pw=0", b_l, b_pw, AR);
    end
    b_rst_n = 1'b1;
    step();
    checks++;
    if (b_l !== AR) begin
      failures++;
      $display("FAIL b_allred2 lamps=%b expected %b", b_l, AR);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (b_l !== NG) begin
        failures++;
        $display("FAIL b_ns_green[%0d] lamps=%b expected %b", i, b_l, NG);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (b_l !== NY) begin
        failures++;
        $display("FAIL b_ns_yel[%0d] lamps=%b expected %b", i, b_l, NY);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (b_l !== AR) begin
        failures++;
        $display("FAIL b_clear[%0d] lamps=%b expected %b", i, b_l, AR);
      end
    end
    step();
    checks++;
    if (b_l !== EG || b_pw !== 1'b0) begin
      failures++;
      $display("FAIL b_ew1 lamps=%b pw=%b expected lamps=%b pw=0", b_l, b_pw, EG);
    end
    b_ped = 1'b1;
    step();
    b_ped = 1'b0;
    checks++;
    if (b_l !== EG || b_pw !== 1'b1) begin
      failures++;
      $display("FAIL b_ew2 lamps=%b pw=%b expected lamps=%b pw=1", b_l, b_pw, EG);
    end
    step();
    checks++;
    if (b_l !== EG || b_pw !== 1'b1) begin
      failures++;
      $display("FAIL b_ew3 lamps=%b pw=%b expected lamps=%b pw=1", b_l, b_pw, EG);
    end
    b_rst_n = 1'b0;
    step();
    b_rst_n = 1'b1;
    checks++;
    if (b_l !== AR || b_pw !== 1'b0) begin
      failures++;
      $display("FAIL b_mid_reset lamps=%b pw=%b expected lamps=%b pw=0", b_l, b_pw, AR);
    end
    step();
    checks++;
    if (b_l !== AR || b_pw !== 1'b0) begin
      failures++;
      $display("FAIL b_post_allred lamps=%b pw=%b expected lamps=%b pw=0", b_l, b_pw, AR);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (b_l !== NG || b_pw !== 1'b0) begin
        failures++;
        $display("FAIL b_post_green[%0d] lamps=%b pw=%b expected lamps=%b pw=0", i, b_l, b_pw, NG);
      end
    end
    step();
    checks++;
    if (b_l !== NY) begin
      failures++;
      $display("FAIL b_post_yel lamps=%b expected %b", b_l, NY);
    end
  endtask

  // Test 6: all durations 1; a request on the ALLRED done edge is served at once.
  task automatic test_unit_durations();
    logic [8:0] v [9] = '{
      {1'b0, NG, 1'b0}, {1'b0, NY, 1'b0}, {1'b0, AR, 1'b0}, {1'b0, EG, 1'b0},
      {1'b0, EY, 1'b0}, {1'b0, AR, 1'b0}, {1'b1, WK, 1'b0}, {1'b0, NG, 1'b0},
      {1'b0, NY, 1'b0}};
    c_rst_n = 1'b0;
    c_ped   = 1'b0;
    step();
    checks++;
    if (c_l !== AR || c_pw !== 1'b0) begin
      failures++;
      $display("FAIL c_reset lamps=%b pw=%b expected lamps=%b pw=0", c_l, c_pw, AR);
    end
    c_rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      c_ped = v[i][8];
      step();
      checks++;
      if (c_l !== v[i][7:1] || c_pw !== v[i][0]) begin
        failures++;
        $display("FAIL unit_dur[%0d] lamps=%b pw=%b expected lamps=%b pw=%b", i, c_l, c_pw, v[i][7:1], v[i][0]);
      end
    end
    c_ped = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ped_pulse();
    test_ped_in_walk();
    test_ped_held();
    test_reset_mid();
    test_unit_durations();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
